// File: rtl/command_scheduler_if.sv
// Command-scheduler bus: command push, register/framebuffer/readback targets, status.
// errCount is present only when CMD_ERR_COUNT_EN is defined.
interface command_scheduler_if;
    logic        cmdValid;
    logic [15:0] cmdIn;
    logic [15:0] dataIn;
    logic        regWrEn;
    logic [7:0]  regAddr;
    logic [15:0] regData;
    logic        fbReq;
    logic [11:0] fbAddr;
    logic [15:0] fbData;
    logic        fbAck;
    logic        rdReq;
    logic [11:0] rdAddr;
    logic        rdValid;
    logic [15:0] rdData;
    logic [15:0] readData;
    logic        busy;
    logic        overflow;
    logic        timeout;
`ifdef CMD_ERR_COUNT_EN
    logic [7:0]  errCount;

    modport master (
        output cmdValid, cmdIn, dataIn, fbAck, rdValid, rdData,
        input  regWrEn, regAddr, regData, fbReq, fbAddr, fbData,
               rdReq, rdAddr, readData, busy, overflow, timeout, errCount
    );
    modport slave (
        input  cmdValid, cmdIn, dataIn, fbAck, rdValid, rdData,
        output regWrEn, regAddr, regData, fbReq, fbAddr, fbData,
               rdReq, rdAddr, readData, busy, overflow, timeout, errCount
    );
`else
    modport master (
        output cmdValid, cmdIn, dataIn, fbAck, rdValid, rdData,
        input  regWrEn, regAddr, regData, fbReq, fbAddr, fbData,
               rdReq, rdAddr, readData, busy, overflow, timeout
    );
    modport slave (
        input  cmdValid, cmdIn, dataIn, fbAck, rdValid, rdData,
        output regWrEn, regAddr, regData, fbReq, fbAddr, fbData,
               rdReq, rdAddr, readData, busy, overflow, timeout
    );
`endif
endinterface

// File: rtl/command_scheduler.sv
// Buffers {command, data} pairs in a FIFO and executes them one at a time on gpuClk.
// Optional illegal-opcode counter enabled by defining CMD_ERR_COUNT_EN.
module command_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FB_TIMEOUT = 255
) (
    input  logic                i_gpuClk,
    input  logic                i_resetN,
    command_scheduler_if.slave  bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_REG_WR  = 3'd2;
    localparam logic [2:0] S_FB_WAIT = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;

    localparam logic [7:0] TO_LAST = 8'(FB_TIMEOUT - 1);

    logic [31:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic [31:0] r_hold;
    logic [2:0]  r_state;
    logic [7:0]  r_waitCnt;
    logic        r_regWrEn, r_fbReq, r_rdReq;
    logic [7:0]  r_regAddr;
    logic [15:0] r_regData, r_fbData, r_readData;
    logic [11:0] r_fbAddr, r_rdAddr;
    logic        r_overflow, r_timeout;
`ifdef CMD_ERR_COUNT_EN
    logic [7:0]  r_errCount;
`endif

    logic        w_empty, w_full, w_push, w_pop;
    logic [3:0]  w_op;

    // Full is judged on the current pointers, so a push alongside a pop on a full FIFO is dropped.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = bus.cmdValid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_op    = r_hold[31:28];

    always_ff @(posedge i_gpuClk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {bus.cmdIn, bus.dataIn};
        end
    end

    always_ff @(posedge i_gpuClk or negedge i_resetN) begin
        if (!i_resetN) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_hold     <= '0;
            r_state    <= S_IDLE;
            r_waitCnt  <= '0;
            r_regWrEn  <= 1'b0;
            r_fbReq    <= 1'b0;
            r_rdReq    <= 1'b0;
            r_regAddr  <= '0;
            r_regData  <= '0;
            r_fbAddr   <= '0;
            r_fbData   <= '0;
            r_rdAddr   <= '0;
            r_readData <= '0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
`ifdef CMD_ERR_COUNT_EN
            r_errCount <= '0;
`endif
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (bus.cmdValid && w_full) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_hold  <= r_mem[r_rptr[AW-1:0]];
                        r_rptr  <= r_rptr + 1'b1;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (w_op)
                        4'd0: r_state <= S_IDLE;
                        4'd1: begin
                            r_regWrEn <= 1'b1;
                            r_regAddr <= r_hold[23:16];
                            r_regData <= r_hold[15:0];
                            r_state   <= S_REG_WR;
                        end
                        4'd2: begin
                            r_fbReq  <= 1'b1;
                            r_fbAddr <= r_hold[27:16];
                            r_fbData <= r_hold[15:0];
                            r_state  <= S_FB_WAIT;
                        end
                        4'd3: begin
                            r_rdReq  <= 1'b1;
                            r_rdAddr <= r_hold[27:16];
                            r_state  <= S_RD_WAIT;
                        end
                        default: begin
`ifdef CMD_ERR_COUNT_EN
                            if (r_errCount != 8'hFF) begin
                                r_errCount <= r_errCount + 8'd1;
                            end
`endif
                            r_state <= S_IDLE;
                        end
                    endcase
                end
                S_REG_WR: begin
                    r_regWrEn <= 1'b0;
                    r_state   <= S_IDLE;
                end
                S_FB_WAIT: begin
                    if (bus.fbAck || (r_waitCnt == TO_LAST)) begin
                        r_fbReq   <= 1'b0;
                        r_waitCnt <= '0;
                        r_timeout <= r_timeout | !bus.fbAck;
                        r_state   <= S_IDLE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.rdValid) begin
                        r_readData <= bus.rdData;
                        r_rdReq    <= 1'b0;
                        r_waitCnt  <= '0;
                        r_state    <= S_IDLE;
                    end else if (r_waitCnt == TO_LAST) begin
                        r_rdReq   <= 1'b0;
                        r_waitCnt <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.regWrEn  = r_regWrEn;
    assign bus.regAddr  = r_regAddr;
    assign bus.regData  = r_regData;
    assign bus.fbReq    = r_fbReq;
    assign bus.fbAddr   = r_fbAddr;
    assign bus.fbData   = r_fbData;
    assign bus.rdReq    = r_rdReq;
    assign bus.rdAddr   = r_rdAddr;
    assign bus.readData = r_readData;
    assign bus.busy     = !w_empty || (r_state != S_IDLE);
    assign bus.overflow = r_overflow;
    assign bus.timeout  = r_timeout;
`ifdef CMD_ERR_COUNT_EN
    assign bus.errCount = r_errCount;
`endif
endmodule

// File: tb/tb_command_scheduler.sv
// Directed vector bench for command_scheduler; errCount checks run when CMD_ERR_COUNT_EN is defined.
module tb_command_scheduler;
    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_REG  = 2'd1;
    localparam logic [1:0] K_FB   = 2'd2;
    localparam logic [1:0] K_RD   = 2'd3;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] data;
        int          rsp_delay;
        logic [15:0] rd_data;
        logic [1:0]  kind;
        logic [11:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_miss = 0;
    logic [15:0] exp_rd = 16'h0000;

    always #5 clk = ~clk;

    command_scheduler_if bus ();

    command_scheduler #(
        .FIFO_DEPTH(4),
        .FB_TIMEOUT(255)
    ) dut (
        .i_gpuClk(clk),
        .i_resetN(rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] cmd, input logic [15:0] data);
        bus.cmdValid = 1'b1;
        bus.cmdIn    = cmd;
        bus.dataIn   = data;
        step();
        bus.cmdValid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " regWrEn"},  bus.regWrEn,  1'b0);
        check({tag, " fbReq"},    bus.fbReq,    1'b0);
        check({tag, " rdReq"},    bus.rdReq,    1'b0);
        check({tag, " readData"}, bus.readData, 16'h0000);
        check({tag, " busy"},     bus.busy,     1'b0);
        check({tag, " overflow"}, bus.overflow, 1'b0);
        check({tag, " timeout"},  bus.timeout,  1'b0);
        check({tag, " regAddr"},  bus.regAddr,  8'h00);
        check({tag, " fbAddr"},   bus.fbAddr,   12'h000);
`ifdef CMD_ERR_COUNT_EN
        check({tag, " errCount"}, bus.errCount, 8'h00);
`endif
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          reg_n = 0;
        int          reg_cyc = -1;
        int          fb_n = 0;
        int          rd_n = 0;
        logic        busy_after = 1'b1;
        logic        stable = 1'b1;
        logic [7:0]  r_addr = '0;
        logic [15:0] r_data = '0;
        logic [11:0] f_addr = '0;
        logic [15:0] f_data = '0;
        logic [11:0] q_addr = '0;
        push(v.cmd, v.data);
        for (int c = 1; c <= 14; c++) begin
            bus.fbAck   = 1'b0;
            bus.rdValid = 1'b0;
            if (reg_cyc >= 0 && c == reg_cyc + 1) busy_after = bus.busy;
            if (bus.regWrEn) begin
                reg_n++;
                if (reg_cyc < 0) reg_cyc = c;
                r_addr = bus.regAddr;
                r_data = bus.regData;
            end
            if (bus.fbReq) begin
                if (fb_n == 0) begin
                    f_addr = bus.fbAddr;
                    f_data = bus.fbData;
                end else if (bus.fbAddr != f_addr || bus.fbData != f_data) begin
                    stable = 1'b0;
                end
                fb_n++;
                if (fb_n == v.rsp_delay) bus.fbAck = 1'b1;
            end
            if (bus.rdReq) begin
                if (rd_n == 0) q_addr = bus.rdAddr;
                rd_n++;
                if (rd_n == v.rsp_delay) begin
                    bus.rdValid = 1'b1;
                    bus.rdData  = v.rd_data;
                end
            end
            step();
        end
        bus.fbAck   = 1'b0;
        bus.rdValid = 1'b0;
        if (v.kind == K_RD) exp_rd = v.rd_data;

        check($sformatf("v%0d regWrEn pulses", idx), reg_n, (v.kind == K_REG) ? 1 : 0);
        check($sformatf("v%0d fbReq cycles", idx), fb_n, (v.kind == K_FB) ? v.rsp_delay : 0);
        check($sformatf("v%0d rdReq cycles", idx), rd_n, (v.kind == K_RD) ? v.rsp_delay : 0);
        check($sformatf("v%0d readData", idx), bus.readData, exp_rd);
        check($sformatf("v%0d busy end", idx), bus.busy, 1'b0);
        if (v.kind == K_REG) begin
            check($sformatf("v%0d reg latency", idx), reg_cyc, 3);
            check($sformatf("v%0d regAddr", idx), r_addr, v.exp_addr[7:0]);
            check($sformatf("v%0d regData", idx), r_data, v.exp_data);
            check($sformatf("v%0d busy after pulse", idx), busy_after, 1'b0);
        end
        if (v.kind == K_FB) begin
            check($sformatf("v%0d fbAddr", idx), f_addr, v.exp_addr);
            check($sformatf("v%0d fbData", idx), f_data, v.exp_data);
            check($sformatf("v%0d fb stable", idx), stable, 1'b1);
        end
        if (v.kind == K_RD) begin
            check($sformatf("v%0d rdAddr", idx), q_addr, v.exp_addr);
        end
    endtask

    initial begin
        vec_t        vecs[9];
        logic [11:0] got_addr[$];
        logic [15:0] got_data[$];
        logic        prev;
        int          hi;
        int          waited;

        vecs[0] = '{16'h1042, 16'hBEEF, 0, 16'h0000, K_REG,  12'h042, 16'hBEEF};
        vecs[1] = '{16'h2ABC, 16'h1234, 3, 16'h0000, K_FB,   12'hABC, 16'h1234};
        vecs[2] = '{16'h3010, 16'h0000, 2, 16'h5A5A, K_RD,   12'h010, 16'h0000};
        vecs[3] = '{16'h0000, 16'hFFFF, 0, 16'h0000, K_NONE, 12'h000, 16'h0000};
        vecs[4] = '{16'h2FFF, 16'h0000, 1, 16'h0000, K_FB,   12'hFFF, 16'h0000};
        vecs[5] = '{16'h10FF, 16'h0001, 0, 16'h0000, K_REG,  12'h0FF, 16'h0001};
        vecs[6] = '{16'h5123, 16'h4444, 0, 16'h0000, K_NONE, 12'h000, 16'h0000};
        vecs[7] = '{16'h3FFF, 16'h0000, 1, 16'hA5A5, K_RD,   12'hFFF, 16'h0000};
        vecs[8] = '{16'h1A33, 16'hCAFE, 0, 16'h0000, K_REG,  12'h033, 16'hCAFE};

        bus.cmdValid = 1'b0;
        bus.cmdIn    = '0;
        bus.dataIn   = '0;
        bus.fbAck    = 1'b0;
        bus.rdValid  = 1'b0;
        bus.rdData   = '0;
        rst_n        = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Overflow: six FB writes back-to-back with fbAck low; the sixth is dropped.
        for (int i = 1; i <= 6; i++) begin
            push({4'h2, 12'(i)}, 16'(i * 16'h0101));
        end
        check("overflow set", bus.overflow, 1'b1);
        prev = 1'b0;
        for (int c = 0; c < 80; c++) begin
            bus.fbAck = 1'b0;
            if (bus.fbReq && !prev) begin
                got_addr.push_back(bus.fbAddr);
                got_data.push_back(bus.fbData);
                bus.fbAck = 1'b1;
            end
            prev = bus.fbReq;
            step();
        end
        bus.fbAck = 1'b0;
        check("overflow executed count", got_addr.size(), 5);
        for (int i = 0; i < 5 && i < got_addr.size(); i++) begin
            check($sformatf("overflow order addr %0d", i), got_addr[i], 12'(i + 1));
            check($sformatf("overflow order data %0d", i), got_data[i], 16'((i + 1) * 16'h0101));
        end
        check("overflow no timeout", bus.timeout, 1'b0);
        check("overflow busy end", bus.busy, 1'b0);
        check("overflow sticky", bus.overflow, 1'b1);

        // Timeout: fbAck never rises.
        push(16'h2077, 16'h7777);
        hi = 0;
        for (int c = 0; c < 400; c++) begin
            if (bus.fbReq) hi++;
            step();
        end
        check("timeout fbReq cycles", hi, 255);
        check("timeout flag", bus.timeout, 1'b1);
        check("timeout readData kept", bus.readData, exp_rd);
        check("timeout busy end", bus.busy, 1'b0);

        // Asynchronous reset in the middle of RD_WAIT.
        push(16'h3055, 16'h0000);
        waited = 0;
        while (!bus.rdReq && waited < 10) begin
            step();
            waited++;
        end
        check("rd wait reached", bus.rdReq, 1'b1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) step();
        check("post reset rdReq", bus.rdReq, 1'b0);
        check("post reset busy", bus.busy, 1'b0);

`ifdef CMD_ERR_COUNT_EN
        push(16'h7000, 16'h0000);
        push(16'hF123, 16'h0000);
        push(16'h0000, 16'h0000);
        hi = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.regWrEn || bus.fbReq || bus.rdReq) hi++;
            step();
        end
        check("errCount value", bus.errCount, 8'd2);
        check("errCount no strobes", hi, 0);
        check("errCount busy end", bus.busy, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
